timer_arbiter: RTL

- Shares one down-counting timer (the auto-reload timer datapath) between NUM_REQ requesters.
- Each requester presents its own load value and holds a request.
- The block arbitrates round-robin, loads the winner's value, counts it down, and returns a one-cycle done pulse to that requester only.
- Sits between the software-visible timeout requesters and the single hardware counter.

---
 rtl/timer_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: one down-counting timer shared round-robin among NUM_REQ requesters.
// Define TIMER_ARB_FIXED_PRIO_EN to make the lowest-index request win every arbitration.
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] load_value,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         count
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic [WIDTH-1:0]   count_q;
    logic [PW-1:0]      win;
    logic               found;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    assign ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
    // First set request scanning upward from the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
`ifdef TIMER_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % NUM_REQ;
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else if (state_q == IDLE) begin
            done_q <= '0;
            if (found) begin
                grant_q <= NUM_REQ'(1) << win;
                count_q <= load_value[win*WIDTH +: WIDTH];
                busy_q  <= 1'b1;
                state_q <= RUN;
`ifndef TIMER_ARB_FIXED_PRIO_EN
                ptr_q   <= ptr_d;
`endif
            end
        end else if ((req & grant_q) == '0) begin
            // Owner abandoned its request: release silently, no done pulse.
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            state_q <= IDLE;
        end else if (count_q == '0) begin
            done_q  <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            count_q <= count_q - 1'b1;
        end
    end
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;
endmodule
